// File: rtl/text_entry_pkg.sv
// Shared constants and FSM state encoding for the keyboard text-entry block.
package text_entry_pkg;

  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] SC_BKSP     = 8'h66;
  localparam logic [7:0] SC_ESC      = 8'h76;
  localparam logic [7:0] SC_SPACE    = 8'h29;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXT   = 2'd1;
  localparam logic [1:0] ST_BREAK = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    EXT   = ST_EXT,
    BREAK = ST_BREAK
  } fsm_state_e;

endpackage

// File: rtl/text_entry_scan_to_ascii.sv
// Combinational PS/2 set-2 make-code to ASCII map for A-Z and space.
module scan_to_ascii
  import text_entry_pkg::*;
(
  input  logic [7:0] code,
  output logic       is_char,
  output logic [7:0] ascii
);

  // Table lookup; unknown codes report is_char = 0
  always_comb begin
    is_char = 1'b1;
    ascii   = ASCII_SPACE;
    case (code)
      8'h1C: ascii = 8'h41;
      8'h32: ascii = 8'h42;
      8'h21: ascii = 8'h43;
      8'h23: ascii = 8'h44;
      8'h24: ascii = 8'h45;
      8'h2B: ascii = 8'h46;
      8'h34: ascii = 8'h47;
      8'h33: ascii = 8'h48;
      8'h43: ascii = 8'h49;
      8'h3B: ascii = 8'h4A;
      8'h42: ascii = 8'h4B;
      8'h4B: ascii = 8'h4C;
      8'h3A: ascii = 8'h4D;
      8'h31: ascii = 8'h4E;
      8'h44: ascii = 8'h4F;
      8'h4D: ascii = 8'h50;
      8'h15: ascii = 8'h51;
      8'h2D: ascii = 8'h52;
      8'h1B: ascii = 8'h53;
      8'h2C: ascii = 8'h54;
      8'h3C: ascii = 8'h55;
      8'h2A: ascii = 8'h56;
      8'h1D: ascii = 8'h57;
      8'h22: ascii = 8'h58;
      8'h35: ascii = 8'h59;
      8'h1A: ascii = 8'h5A;
      SC_SPACE: ascii = ASCII_SPACE;
      default: begin
        is_char = 1'b0;
        ascii   = ASCII_SPACE;
      end
    endcase
  end

endmodule

// File: rtl/text_entry.sv
// Keyboard line editor: decodes PS/2 set-2 bytes into an edit buffer and
// publishes the line to the text renderer on Enter.
module text_entry
  import text_entry_pkg::*;
#(
  parameter int STRING_LENGTH = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 scan_code,
  input  logic                       scan_valid,
  output logic [STRING_LENGTH*8-1:0] str,
  output logic [5:0]                 numchar,
  output logic                       ready,
  output logic                       custom
);

  localparam int         SW   = STRING_LENGTH * 8;
  localparam logic [5:0] LEN6 = 6'(STRING_LENGTH);

  fsm_state_e    state_r, state_nxt_s;
  logic [SW-1:0] buf_r, buf_nxt_s;
  logic [5:0]    count_r, count_nxt_s;
  logic [SW-1:0] str_r;
  logic [5:0]    numchar_r;
  logic          ready_r, custom_r;

  logic          is_char_s;
  logic [7:0]    ascii_s;
  logic          wr_en_s, commit_s, clear_s;
  logic [5:0]    wr_pos_s;
  logic [7:0]    wr_char_s;

  scan_to_ascii u_map (
    .code    (scan_code),
    .is_char (is_char_s),
    .ascii   (ascii_s)
  );

  // Byte decoder: next state, single-slot buffer write, count update, commit/clear
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    wr_en_s     = 1'b0;
    wr_pos_s    = count_r;
    wr_char_s   = ascii_s;
    commit_s    = 1'b0;
    clear_s     = 1'b0;
    if (scan_valid) begin
      case (state_r)
        IDLE: begin
          if (scan_code == SC_BREAK) begin
            state_nxt_s = BREAK;
          end else if (scan_code == SC_EXT) begin
            state_nxt_s = EXT;
          end else if (is_char_s) begin
            if (count_r < LEN6) begin
              wr_en_s     = 1'b1;
              count_nxt_s = count_r + 6'd1;
            end else begin
              wr_en_s = 1'b0;
            end
          end else if (scan_code == SC_BKSP) begin
            if (count_r != 6'd0) begin
              wr_en_s     = 1'b1;
              wr_pos_s    = count_r - 6'd1;
              wr_char_s   = ASCII_SPACE;
              count_nxt_s = count_r - 6'd1;
            end else begin
              wr_en_s = 1'b0;
            end
          end else if (scan_code == SC_ENTER) begin
            commit_s = 1'b1;
          end else if (scan_code == SC_ESC) begin
            clear_s     = 1'b1;
            count_nxt_s = 6'd0;
          end else begin
            commit_s = 1'b0;
          end
        end
        EXT: begin
          if (scan_code == SC_BREAK) begin
            state_nxt_s = BREAK;
          end else if (scan_code == SC_ENTER) begin
            commit_s    = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        BREAK:   state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Next edit buffer; char i lives at the same bit slot it takes in str
  always_comb begin
    buf_nxt_s = buf_r;
    for (int i = 0; i < STRING_LENGTH; i++) begin
      if (clear_s) begin
        buf_nxt_s[SW-1-8*i -: 8] = ASCII_SPACE;
      end else if (wr_en_s && (6'(i) == wr_pos_s)) begin
        buf_nxt_s[SW-1-8*i -: 8] = wr_char_s;
      end else begin
        buf_nxt_s[SW-1-8*i -: 8] = buf_r[SW-1-8*i -: 8];
      end
    end
  end

  // State, edit buffer and published outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      buf_r     <= {STRING_LENGTH{ASCII_SPACE}};
      count_r   <= 6'd0;
      str_r     <= {STRING_LENGTH{ASCII_SPACE}};
      numchar_r <= 6'd0;
      ready_r   <= 1'b0;
      custom_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      buf_r   <= buf_nxt_s;
      count_r <= count_nxt_s;
      ready_r <= commit_s;
      if (commit_s) begin
        str_r     <= buf_r;
        numchar_r <= count_r;
        custom_r  <= 1'b1;
      end else if (clear_s) begin
        custom_r  <= 1'b0;
      end
    end
  end

  assign str     = str_r;
  assign numchar = numchar_r;
  assign ready   = ready_r;
  assign custom  = custom_r;

endmodule

// File: tb/tb_text_entry.sv
// Scoreboard bench for text_entry: stimulus queues expected commits, a monitor checks each ready pulse.
module tb_text_entry;

  localparam int L = 9;

  typedef struct packed {
    logic [L*8-1:0] s;
    logic [5:0]     n;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     scan_code = 8'h00;
  logic           scan_valid = 1'b0;
  logic [L*8-1:0] str;
  logic [5:0]     numchar;
  logic           ready;
  logic           custom;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [L*8-1:0] SPACES = {L{8'h20}};

  text_entry #(.STRING_LENGTH(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .str        (str),
    .numchar    (numchar),
    .ready      (ready),
    .custom     (custom)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [L*8-1:0] act, input logic [L*8-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest queued commit
  always @(negedge clk) begin
    if (rst_n && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready=1 numchar=%0d expected no pulse", numchar);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_string", str, e.s);
        chk("commit_numchar", {66'd0, numchar}, {66'd0, e.n});
        chk("commit_custom", {71'd0, custom}, {71'd0, 1'b1});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic expect_commit(input logic [L*8-1:0] s, input logic [5:0] n);
    exp_t e;
    e.s = s;
    e.n = n;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] paris [5];
    paris = '{8'h4D, 8'h1C, 8'h2D, 8'h43, 8'h1B};

    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk("reset_string", str, SPACES);
    chk("reset_numchar", {66'd0, numchar}, 72'd0);
    chk("reset_ready", {71'd0, ready}, 72'd0);
    chk("reset_custom", {71'd0, custom}, 72'd0);

    // PARIS with break codes, back-to-back bytes
    for (int k = 0; k < 5; k++) begin
      send(paris[k]);
      send(8'hF0);
      send(paris[k]);
    end
    expect_commit({8'h50, 8'h41, 8'h52, 8'h49, 8'h53, 32'h20202020}, 6'd5);
    send(8'h5A);
    idle(2);

    // Overflow: ten A presses, only nine stick
    send(8'h76);
    for (int k = 0; k < 10; k++) send(8'h1C);
    expect_commit({L{8'h41}}, 6'd9);
    send(8'h5A);
    idle(2);

    // Edit with backspace underflow
    send(8'h76);
    send(8'h1C); send(8'h32);
    send(8'h66); send(8'h66); send(8'h66);
    send(8'h21);
    expect_commit({8'h43, {(L-1){8'h20}}}, 6'd1);
    send(8'h5A);
    idle(2);

    // Break/extended filtering, then keypad Enter
    send(8'h76);
    send(8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'h75);
    idle(3);
    expect_commit({8'h41, {(L-1){8'h20}}}, 6'd1);
    send(8'hE0); send(8'h5A);
    idle(2);

    // Esc after committing AB
    send(8'h76);
    send(8'h1C); send(8'h32);
    expect_commit({8'h41, 8'h42, {(L-2){8'h20}}}, 6'd2);
    send(8'h5A);
    idle(1);
    send(8'h76);
    idle(1);
    chk("esc_custom", {71'd0, custom}, 72'd0);
    chk("esc_string_kept", str, {8'h41, 8'h42, {(L-2){8'h20}}});
    chk("esc_numchar_kept", {66'd0, numchar}, {66'd0, 6'd2});
    expect_commit(SPACES, 6'd0);
    send(8'h5A);
    idle(2);

    // Async reset while a break prefix is pending
    send(8'h1C);
    send(8'hF0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_string", str, SPACES);
    chk("async_rst_numchar", {66'd0, numchar}, 72'd0);
    chk("async_rst_ready", {71'd0, ready}, 72'd0);
    chk("async_rst_custom", {71'd0, custom}, 72'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send(8'h1C);
    expect_commit({8'h41, {(L-1){8'h20}}}, 6'd1);
    send(8'h5A);
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_ready: got %0d pending commits expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
